// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage placed after the execute ALU.
//
// Accepts one instruction at a time. Loads and stores go out on a
// req/gnt/rvalid data-memory bus. Load data is aligned and extended. The
// write-back result goes to the next stage over a valid/ready handshake.
// All other opcodes pass the ALU result straight through.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   valid_i/ready_o   upstream handshake; ready_o is high only in IDLE
//   pc_i, opcode_i, funct3_i, rd_i, alu_res_i, rs2_data_i
//                     instruction fields; alu_res_i is the address for ld/st
//   dmem_req_o/we/addr/be/wdata, dmem_gnt_i
//                     request phase; fields are zero when no request is open
//   dmem_rvalid_i, dmem_rdata_i
//                     load response; only honoured while waiting for one
//   valid_o/ready_i   downstream handshake
//   pc_o, rd_o, wb_data_o
//                     registered write-back payload
//   misalign_o        misaligned-access flag
//
// Optional build macro MEM_MISALIGN_TRAP_EN:
//   When defined, a misaligned halfword or word access is not sent to the bus.
//   The stage returns wb_data_o=0 with misalign_o=1 instead.
//   When undefined, misalign_o is tied to 0 and the access is force-aligned.
module mem_access_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              misalign_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] rs2_q, rs2_d;
  logic [DWIDTH-1:0] wb_q, wb_d;

  logic              is_load, is_store, load_ok, store_ok;
  logic [1:0]        lane_off;
  logic [3:0]        lane_be;
  logic [DWIDTH-1:0] lane_wdata;
  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] load_data;

  // Decode of the incoming instruction. It is only used in the accept cycle.
  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign load_ok  = is_load  && (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign store_ok = is_store && (funct3_i inside {3'b000, 3'b001, 3'b010});

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic in_misalign;
  assign in_misalign = ((funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (alu_res_i[1:0] != 2'b00));
  assign misalign_o  = misalign_q;
`else
  assign misalign_o  = 1'b0;
`endif

  // Byte-lane offset. A misaligned halfword keeps only a[1], and a word
  // always uses lane 0. With the trap enabled, misaligned accesses never
  // reach the bus, so this force-alignment has no effect in that build.
  always_comb begin
    lane_off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b01:   lane_off = {addr_q[1], 1'b0};
      2'b10:   lane_off = 2'b00;
      default: lane_off = addr_q[1:0];
    endcase
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = rs2_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << lane_off;
        lane_wdata = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << lane_off;
        lane_wdata = {2{rs2_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = rs2_q;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend the value.
  assign shifted = dmem_rdata_i >> {lane_off, 3'b000};
  always_comb begin
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    rs2_d      = rs2_q;
    wb_d       = wb_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          pc_d       = pc_i;
          rd_d       = rd_i;
          funct3_d   = funct3_i;
          is_store_d = is_store;
          addr_d     = alu_res_i[AWIDTH-1:0];
          rs2_d      = rs2_data_i;
          if (load_ok || store_ok) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (in_misalign) begin
              state_d    = OUT;
              wb_d       = '0;
              misalign_d = 1'b1;
            end else begin
              state_d = REQ;
            end
`else
            state_d = REQ;
`endif
          end else begin
            // Reserved load/store encodings complete with zero and no bus cycle.
            state_d = OUT;
            wb_d    = (is_load || is_store) ? '0 : alu_res_i;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          if (is_store_q) begin
            state_d = OUT;
            wb_d    = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          wb_d    = load_data;
          state_d = OUT;
        end
      end
      OUT: begin
        if (ready_i) begin
          state_d = IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      rs2_q      <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      rs2_q      <= rs2_d;
      wb_q       <= wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`endif

  // Bus fields are zeroed outside REQ. An asynchronous reset therefore drops
  // the request at once, because the state register clears immediately.
  assign ready_o      = (state_q == IDLE) && !reset;
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = dmem_req_o && is_store_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? lane_be : 4'b0000;
  assign dmem_wdata_o = dmem_req_o ? lane_wdata : '0;
  assign valid_o      = (state_q == OUT);
  assign pc_o         = pc_q;
  assign rd_o         = rd_q;
  assign wb_data_o    = wb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage. The stimulus pushes the expected
// write-back and bus transactions. Two monitors compare on valid_o and on
// dmem_req_o. A responder process models the data memory.
module tb_mem_access_stage;
  logic        clk = 0;
  logic        reset = 0;
  logic        valid_i = 0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] alu_res_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 0;
  logic        dmem_rvalid_i = 0;
  logic [31:0] dmem_rdata_i = '0;
  logic        valid_o;
  logic        ready_i = 1;
  logic [31:0] pc_o;
  logic [4:0]  rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  mem_access_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .alu_res_i(alu_res_i), .rs2_data_i(rs2_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .rd_o(rd_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        mis;
    int          at_cyc;
  } out_t;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          reqs;
  } bus_t;
  out_t out_q[$];
  bus_t bus_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder. It drives just after each rising edge. gnt_dly is the
  // number of extra request cycles before the grant. rv_dly is the number of
  // extra cycles after the cycle following the grant.
  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic [31:0] rdata_v = '0;
  bit          late_rv = 0;
  int          rq_cnt = 0;
  int          rv_cnt = 0;
  bit          rv_pend = 0;
  initial forever begin
    @(posedge clk);
    #1;
    dmem_gnt_i    = 0;
    dmem_rvalid_i = 0;
    if (reset) begin
      rq_cnt  = 0;
      rv_pend = 0;
    end else begin
      if (late_rv) begin
        dmem_rvalid_i = 1;
        dmem_rdata_i  = rdata_v;
        late_rv       = 0;
      end
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          dmem_rvalid_i = 1;
          dmem_rdata_i  = rdata_v;
          rv_pend       = 0;
        end else begin
          rv_cnt--;
        end
      end
      if (dmem_req_o) begin
        if (rq_cnt == gnt_dly) begin
          dmem_gnt_i = 1;
          rq_cnt     = 0;
          if (!dmem_we_o) begin
            rv_pend = 1;
            rv_cnt  = rv_dly;
          end
        end else begin
          rq_cnt++;
        end
      end
    end
  end

  // Write-back monitor.
  out_t eo;
  bit   prev_valid = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (valid_o) begin
        if (out_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, valid_o}, 32'd0);
        end else begin
          eo = out_q[0];
          chk("wb_data", wb_data_o, eo.wb);
          chk("rd", {27'd0, rd_o}, {27'd0, eo.rd});
          chk("pc", pc_o, eo.pc);
          chk("misalign", {31'd0, misalign_o}, {31'd0, eo.mis});
          chk("ready_o_in_out", {31'd0, ready_o}, 32'd0);
          if (!prev_valid) chk("latency", cyc, eo.at_cyc);
          if (ready_i) begin
            $display("wb   pc=%08h rd=%0d data=%08h mis=%0b", pc_o, rd_o, wb_data_o, misalign_o);
            void'(out_q.pop_front());
          end
        end
      end
      prev_valid = valid_o;
    end
  end

  // Bus monitor. The fields must match on every request cycle, which also
  // checks that they stay stable until the grant.
  bus_t eb;
  int   req_seen = 0;
  always @(negedge clk) begin
    if (reset) begin
      req_seen = 0;
    end else if (dmem_req_o) begin
      req_seen++;
      if (bus_q.size() == 0) begin
        chk("unexpected_req", {31'd0, dmem_req_o}, 32'd0);
      end else begin
        eb = bus_q[0];
        chk("dmem_addr", dmem_addr_o, eb.addr);
        chk("dmem_be", {28'd0, dmem_be_o}, {28'd0, eb.be});
        chk("dmem_wdata", dmem_wdata_o, eb.wdata);
        chk("dmem_we", {31'd0, dmem_we_o}, {31'd0, eb.we});
        chk("ready_o_in_req", {31'd0, ready_o}, 32'd0);
        if (dmem_gnt_i) begin
          chk("req_cycles", req_seen, eb.reqs);
          $display("bus  addr=%08h be=%04b we=%0b wdata=%08h", dmem_addr_o, dmem_be_o, dmem_we_o, dmem_wdata_o);
          void'(bus_q.pop_front());
          req_seen = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((out_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", out_q.size() + bus_q.size(), 0);
    if (n >= 100) begin
      out_q.delete();
      bus_q.delete();
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                       input int gd, input int rvd, input logic [31:0] rdata,
                       input bit has_bus, input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] wb, input logic mis, input int lat, input bit do_wait);
    out_t e;
    bus_t b;
    int   n = 0;
    gnt_dly = gd;
    rv_dly  = rvd;
    rdata_v = rdata;
    @(posedge clk);
    #1;
    while (!ready_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_o) chk("accept_timeout", {31'd0, ready_o}, 32'd1);
    valid_i    = 1;
    opcode_i   = op;
    funct3_i   = f3;
    rd_i       = rd;
    alu_res_i  = alu;
    rs2_data_i = rs2;
    pc_i       = pc;
    e.pc = pc; e.rd = rd; e.wb = wb; e.mis = mis; e.at_cyc = cyc + lat;
    out_q.push_back(e);
    if (has_bus) begin
      b.addr = {alu[31:2], 2'b00}; b.be = be; b.wdata = wdata;
      b.we = (op == OP_ST); b.reqs = gd + 1;
      bus_q.push_back(b);
    end
    @(posedge clk);
    #1;
    valid_i = 0;
    if (do_wait) wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e2;
    int   r;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd0);
    chk("rst_wb", wb_data_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    #1 reset = 0;
    #1 chk("ready_after_rst", {31'd0, ready_o}, 32'd1);

    // op, f3, rd, alu, rs2, pc, gnt_dly, rv_dly, rdata, bus, be, wdata, wb, mis, lat, wait
    issue(OP_ALU, 3'b000, 5'd1, 32'h0000_0015, 32'h0, 32'h100, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0000_0015, 0, 1, 1);
    issue(OP_ST,  3'b000, 5'd2, 32'h0000_1003, 32'h0000_00AB, 32'h104, 0, 0, 32'h0, 1, 4'b1000, 32'hABAB_ABAB, 32'h0, 0, 2, 1);
    issue(OP_LD,  3'b000, 5'd3, 32'h0000_2001, 32'h0, 32'h108, 0, 0, 32'h1234_80FF, 1, 4'b0010, 32'h0, 32'hFFFF_FF80, 0, 3, 1);
    issue(OP_LD,  3'b100, 5'd4, 32'h0000_2001, 32'h0, 32'h10C, 0, 0, 32'h1234_80FF, 1, 4'b0010, 32'h0, 32'h0000_0080, 0, 3, 1);
    issue(OP_LD,  3'b001, 5'd5, 32'h0000_2002, 32'h0, 32'h110, 0, 0, 32'h1234_80FF, 1, 4'b1100, 32'h0, 32'h0000_1234, 0, 3, 1);
    issue(OP_LD,  3'b001, 5'd6, 32'h0000_2000, 32'h0, 32'h114, 0, 0, 32'h1234_80FF, 1, 4'b0011, 32'h0, 32'hFFFF_80FF, 0, 3, 1);
    issue(OP_LD,  3'b101, 5'd7, 32'h0000_2000, 32'h0, 32'h118, 0, 0, 32'h1234_80FF, 1, 4'b0011, 32'h0, 32'h0000_80FF, 0, 3, 1);
    issue(OP_ST,  3'b001, 5'd8, 32'h0000_4002, 32'hDEAD_BEEF, 32'h11C, 0, 0, 32'h0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 2, 1);
    issue(OP_ST,  3'b010, 5'd9, 32'h0000_4004, 32'h0123_4567, 32'h120, 0, 0, 32'h0, 1, 4'b1111, 32'h0123_4567, 32'h0, 0, 2, 1);
    // Stalled LW: grant on the 4th request cycle, data two cycles after it.
    issue(OP_LD,  3'b010, 5'd10, 32'h0000_5000, 32'h0, 32'h124, 3, 1, 32'hCAFE_F00D, 1, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 7, 1);
    // Reserved encodings complete with zero and no bus activity.
    issue(OP_LD,  3'b011, 5'd11, 32'h0000_0010, 32'h0, 32'h128, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 1);
    issue(OP_ST,  3'b100, 5'd12, 32'h0000_0010, 32'h5555_5555, 32'h12C, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    issue(OP_LD,  3'b010, 5'd13, 32'h0000_3002, 32'h0, 32'h130, 0, 0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h0, 1, 1, 1);
    issue(OP_LD,  3'b001, 5'd14, 32'h0000_2003, 32'h0, 32'h134, 0, 0, 32'h1234_80FF, 0, 4'b0000, 32'h0, 32'h0, 1, 1, 1);
`else
    issue(OP_LD,  3'b010, 5'd13, 32'h0000_3002, 32'h0, 32'h130, 0, 0, 32'h1122_3344, 1, 4'b1111, 32'h0, 32'h1122_3344, 0, 3, 1);
    issue(OP_LD,  3'b001, 5'd14, 32'h0000_2003, 32'h0, 32'h134, 0, 0, 32'h1234_80FF, 1, 4'b1100, 32'h0, 32'h0000_1234, 0, 3, 1);
`endif

    // Downstream stall. A second instruction waits on valid_i and must not
    // enter until the cycle after the handoff.
    ready_i = 0;
    issue(OP_ALU, 3'b000, 5'd15, 32'h0000_0077, 32'h0, 32'h700, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0000_0077, 0, 1, 0);
    valid_i   = 1;
    opcode_i  = OP_ALU;
    rd_i      = 5'd16;
    alu_res_i = 32'h0000_0088;
    pc_i      = 32'h800;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    r = cyc;
    e2.pc = 32'h800; e2.rd = 5'd16; e2.wb = 32'h0000_0088; e2.mis = 0; e2.at_cyc = r + 2;
    out_q.push_back(e2);
    ready_i = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    valid_i = 0;
    wait_idle();

    // Reset while a request is open: the request must drop without a clock edge.
    issue(OP_LD, 3'b010, 5'd17, 32'h0000_6000, 32'h0, 32'h140, 30, 0, 32'h0, 1, 4'b1111, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("async_rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("async_rst_ready", {31'd0, ready_o}, 32'd0);
    out_q.delete();
    bus_q.delete();
    @(negedge clk);
    #1 reset = 0;

    // Reset while waiting for load data. A late rvalid must be ignored.
    issue(OP_LD, 3'b010, 5'd18, 32'h0000_6000, 32'h0, 32'h144, 0, 5, 32'hDEAD_0000, 1, 4'b1111, 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("wait_rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("wait_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("wait_rst_wb", wb_data_o, 32'd0);
    out_q.delete();
    bus_q.delete();
    @(negedge clk);
    #1 reset = 0;
    late_rv = 1;
    @(negedge clk);
    #1;
    chk("late_rv_wb", wb_data_o, 32'd0);
    chk("late_rv_valid", {31'd0, valid_o}, 32'd0);
    chk("late_rv_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("late_rv_wb2", wb_data_o, 32'd0);

    // Normal operation after the abort.
    issue(OP_ALU, 3'b000, 5'd19, 32'h0000_0099, 32'h0, 32'h150, 0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0000_0099, 0, 1, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute ALU.
- Takes the ALU result (the effective address for loads/stores, the final value otherwise) and performs data-memory loads/stores over a req/gnt/rvalid bus.
- Aligns and extends load data and presents write-back data to the next stage through a valid/ready handshake.
- Multi-cycle: holds its input slot until the memory transaction and downstream handoff complete.

Parameters:
- DWIDTH, 32, data width; fixed at 32 for byte-lane logic.
- AWIDTH, 32, address/PC width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  upstream has an instruction.
- ready_o  output  1  stage can accept; high only in IDLE.
- pc_i  input  AWIDTH  instruction PC.
- opcode_i  input  7  instruction opcode.
- funct3_i  input  3  access size/sign.
- rd_i  input  5  destination register.
- alu_res_i  input  DWIDTH  ALU result / effective address.
- rs2_data_i  input  DWIDTH  store data.
- dmem_req_o  output  1  memory request.
- dmem_we_o  output  1  1=store, 0=load.
- dmem_addr_o  output  AWIDTH  word-aligned address ({addr[AWIDTH-1:2],2'b00}).
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  DWIDTH  lane-aligned store data.
- dmem_gnt_i  input  1  request accepted this cycle.
- dmem_rvalid_i  input  1  load data valid.
- dmem_rdata_i  input  DWIDTH  load data (full word).
- valid_o  output  1  write-back data valid.
- ready_i  input  1  downstream accepts.
- pc_o  output  AWIDTH  registered PC.
- rd_o  output  5  registered rd.
- wb_data_o  output  DWIDTH  write-back data.
- misalign_o  output  1  misaligned access flag (feature only; else tied 0).

Behaviour:
- Reset: state=IDLE; ready_o=1 only after reset deasserts; all other outputs 0, including valid_o, dmem_req_o, wb_data_o, pc_o, rd_o, misalign_o.
- Reset mid-transaction aborts immediately: dmem_req_o drops asynchronously. Any later rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, OUT.
- Accept occurs when valid_i && ready_o. On accept, register pc, rd, opcode, funct3, alu_res, rs2_data.
  - Load (0000011) with funct3 in {000,001,010,100,101} -> REQ, we=0.
  - Store (0100011) with funct3 in {000,001,010} -> REQ, we=1.
  - Any other opcode -> OUT, wb_data_o=alu_res_i.
  - Reserved load/store funct3 -> OUT, wb_data_o=0, no bus activity.
- REQ:
  - dmem_req_o=1 and bus fields stable until dmem_gnt_i.
  - On gnt: load -> WAIT; store -> OUT with wb_data_o=0.
- WAIT:
  - dmem_req_o=0; wait for dmem_rvalid_i.
  - On rvalid, capture extracted data into wb_data_o -> OUT.
  - rvalid outside WAIT is ignored.
- OUT:
  - valid_o=1; outputs held stable until ready_i.
  - On ready_i -> IDLE, valid_o=0 next cycle. No accept in the same cycle (ready_o=0 in OUT).
- Byte enables and store data (a=addr[1:0]):
  - SB: be=0001<<a, wdata=byte replicated x4.
  - SH: be=0011 (a[1]=0) or 1100 (a[1]=1), wdata=half replicated x2.
  - SW: be=1111, wdata=rs2.
  - Loads drive be the same way per size.
- Load extract:
  - shifted = rdata >> (8*a).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Latency with gnt in the first REQ cycle and rvalid one cycle later:
  - non-memory op: valid_o at accept+1.
  - store: valid_o at accept+2.
  - load: valid_o at accept+3.
- Stalls: gnt/rvalid waits extend REQ/WAIT indefinitely. No timeout.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with a[0]=1, or word access with a!=0, makes no bus request. State goes IDLE->OUT, wb_data_o=0, misalign_o=1 alongside valid_o.
  - misalign_o clears on handoff.
- Undefined:
  - misalign_o tied 0.
  - Misaligned halfword uses a[1] only; misaligned word is forced to a=00; the access proceeds normally.

Test Plan:
- ADD result 0x0000_0015, ready_i=1 -> valid_o one cycle after accept, wb_data_o=0x15, no dmem_req_o.
- SB addr 0x1003, rs2=0x0000_00AB, gnt immediate -> dmem_addr_o=0x1000, be=1000, wdata=0xABABABAB, we=1, valid_o at accept+2, wb_data_o=0.
- LB addr 0x2001, rdata=0x1234_80FF -> wb_data_o=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr 0x2002 -> 0x0000_1234.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> dmem_req_o held 4 cycles with stable addr/be, ready_o=0 throughout, correct word out.
- Downstream ready_i low 5 cycles in OUT -> valid_o, wb_data_o, rd_o stable; valid_i ignored; accept resumes the cycle after the handoff.
- Reset asserted during WAIT -> dmem_req_o/valid_o 0 immediately, state IDLE; a late rvalid does not update wb_data_o. With MEM_MISALIGN_TRAP_EN, LW at 0x3002 -> misalign_o=1, no request.
